// File: rtl/keypad_scanner_if.sv
// Keypad scanner bus: matrix lines plus the debounced key report.
//   row_in    : keypad rows, active-low, asynchronous to the scan clock
//   col_out   : keypad columns, active-low one-cold
//   key_code  : last accepted key, row*4 + col
//   key_valid : one-cycle pulse when key_code updates
//   key_down  : high from accepted press until accepted release
// master = the scanner, slave = keypad/consumer side.
interface keypad_scanner_if;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  modport master (
    input  row_in,
    output col_out, key_code, key_valid, key_down
  );

  modport slave (
    output row_in,
    input  col_out, key_code, key_valid, key_down
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner. Drives one column low at a time, samples the
// synchronized rows at the end of each column dwell, debounces a press and
// its release, and reports one key code per press.
//   divided_clk : scan clock, rising edge
//   rst_n       : asynchronous active-low reset
//   bus         : keypad_scanner_if.master (rows in, columns and key report out)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// SCAN     | walk columns, sample rows at the last dwell cycle
// DEBOUNCE | column frozen, require a stable captured row pattern
// HOLD     | key accepted, column frozen, wait for a stable release
module keypad_scanner #(
  parameter int DWELL           = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              divided_clk,
  input  logic              rst_n,
  keypad_scanner_if.master  bus
);

  localparam int MAXP = (DWELL > DEBOUNCE_CYCLES) ? DWELL : DEBOUNCE_CYCLES;
  localparam int CW   = (MAXP > 1) ? $clog2(MAXP) : 1;

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD} state_t;

  state_t        state, state_nxt;
  logic [3:0]    sync1, row_s;
  logic [CW-1:0] dwell_cnt, dwell_nxt;
  logic [CW-1:0] deb_cnt, deb_nxt;
  logic [1:0]    col_idx, col_nxt;
  logic [1:0]    cap_row, cap_row_nxt;
  logic [3:0]    cap_pat, cap_pat_nxt;
  logic [3:0]    key_code_r, code_nxt;
  logic          key_valid_r, valid_nxt;
  logic          key_down_r, down_nxt;
  logic [1:0]    low_row;

  always_ff @(posedge divided_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 4'b1111;
      row_s <= 4'b1111;
    end else begin
      sync1 <= bus.row_in;
      row_s <= sync1;
    end
  end

  // Lowest-numbered pressed row wins when several rows are low.
  always_comb begin
    low_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_s[i]) low_row = 2'(i);
    end
  end

  always_ff @(posedge divided_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SCAN;
      dwell_cnt   <= '0;
      deb_cnt     <= '0;
      col_idx     <= 2'd0;
      cap_row     <= 2'd0;
      cap_pat     <= 4'b1111;
      key_code_r  <= 4'h0;
      key_valid_r <= 1'b0;
      key_down_r  <= 1'b0;
    end else begin
      state       <= state_nxt;
      dwell_cnt   <= dwell_nxt;
      deb_cnt     <= deb_nxt;
      col_idx     <= col_nxt;
      cap_row     <= cap_row_nxt;
      cap_pat     <= cap_pat_nxt;
      key_code_r  <= code_nxt;
      key_valid_r <= valid_nxt;
      key_down_r  <= down_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    dwell_nxt   = dwell_cnt;
    deb_nxt     = deb_cnt;
    col_nxt     = col_idx;
    cap_row_nxt = cap_row;
    cap_pat_nxt = cap_pat;
    code_nxt    = key_code_r;
    valid_nxt   = 1'b0;
    down_nxt    = key_down_r;
    case (state)
      SCAN: begin
        if (dwell_cnt == CW'(DWELL - 1)) begin
          dwell_nxt = '0;
          if (row_s == 4'b1111) begin
            col_nxt = col_idx + 2'd1;
          end else begin
            cap_row_nxt = low_row;
            cap_pat_nxt = row_s;
            deb_nxt     = '0;
            state_nxt   = DEBOUNCE;
          end
        end else begin
          dwell_nxt = dwell_cnt + CW'(1);
        end
      end
      DEBOUNCE: begin
        if (row_s == cap_pat) begin
          if (deb_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            code_nxt  = {cap_row, col_idx};
            valid_nxt = 1'b1;
            down_nxt  = 1'b1;
            deb_nxt   = '0;
            state_nxt = HOLD;
          end else begin
            deb_nxt = deb_cnt + CW'(1);
          end
        end else begin
          // Bounce: give up on this column and keep scanning.
          col_nxt   = col_idx + 2'd1;
          dwell_nxt = '0;
          deb_nxt   = '0;
          state_nxt = SCAN;
        end
      end
      HOLD: begin
        // Only an all-high run counts as release; other row changes in the
        // frozen column (second key, partial release) just restart the run.
        if (row_s == 4'b1111) begin
          if (deb_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            down_nxt  = 1'b0;
            col_nxt   = col_idx + 2'd1;
            dwell_nxt = '0;
            deb_nxt   = '0;
            state_nxt = SCAN;
          end else begin
            deb_nxt = deb_cnt + CW'(1);
          end
        end else begin
          deb_nxt = '0;
        end
      end
      default: begin
        state_nxt = SCAN;
        dwell_nxt = '0;
        deb_nxt   = '0;
      end
    endcase
  end

  assign bus.col_out   = ~(4'b0001 << col_idx);
  assign bus.key_code  = key_code_r;
  assign bus.key_valid = key_valid_r;
  assign bus.key_down  = key_down_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner (DWELL = 4, DEBOUNCE_CYCLES = 4).
// A keypad model turns the pressed-key map and col_out into row_in; every
// key_valid pulse is logged by a monitor and matched against a queue of
// expected key codes.
module tb_keypad_scanner;

  localparam int DWELL   = 4;
  localparam int DEB     = 4;
  localparam int MAX_LAT = 2 + 4 * DWELL + DEB + 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pressed;
  logic        ovr_en;
  logic [3:0]  ovr_val;
  int          cyc = 0;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          rd_idx  = 0;
  int          n_exp   = 0;
  logic [3:0]  exp_q[$];
  logic [3:0]  obs_q[$];
  int          obs_cyc[$];

  typedef struct {
    int         row;
    int         col;
    logic [3:0] code;
  } vec_t;
  vec_t vecs[4];

  keypad_scanner_if kp();

  keypad_scanner #(.DWELL(DWELL), .DEBOUNCE_CYCLES(DEB)) dut (
    .divided_clk (clk),
    .rst_n       (rst_n),
    .bus         (kp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    logic [3:0] rows;
    rows = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !kp.col_out[c]) rows[r] = 1'b0;
    kp.row_in = ovr_en ? ovr_val : rows;
  end

  always @(negedge clk) begin
    if (kp.key_valid === 1'b1) begin
      obs_q.push_back(kp.key_code);
      obs_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] col_mask(input int c);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << c);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic expect_key(input logic [3:0] code);
    exp_q.push_back(code);
    n_exp++;
  endtask

  task automatic sb_check();
    logic [3:0] e;
    while (rd_idx < obs_q.size()) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_key_valid: got code %0h, required no pulse", obs_q[rd_idx]);
      end else begin
        e = exp_q.pop_front();
        check("sb_key_code", 32'(obs_q[rd_idx]), 32'(e));
      end
      rd_idx++;
    end
  endtask

  task automatic wait_pulse(input int n0, input int bound, output logic got);
    got = 1'b0;
    for (int i = 0; i < bound && !got; i++) begin
      @(negedge clk);
      if (obs_q.size() > n0) got = 1'b1;
    end
  endtask

  task automatic wait_fall(input int bound, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (kp.key_down && n < bound);
  endtask

  initial begin
    logic got;
    int   n0, t0, nf, bad, changes;
    logic [3:0] prev;

    vecs[0] = '{2, 1, 4'h9};
    vecs[1] = '{0, 0, 4'h0};
    vecs[2] = '{3, 2, 4'hE};
    vecs[3] = '{1, 3, 4'h7};

    // Reset with arbitrary rows forced low.
    rst_n = 1'b0; ovr_en = 1'b1; ovr_val = 4'b0000; pressed = '0;
    repeat (3) @(negedge clk);
    check("rst_col_out",   32'(kp.col_out),   32'(4'b1110));
    check("rst_key_code",  32'(kp.key_code),  32'(4'h0));
    check("rst_key_valid", 32'(kp.key_valid), 32'(1'b0));
    check("rst_key_down",  32'(kp.key_down),  32'(1'b0));
    rst_n = 1'b1; ovr_en = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check("idle_scan_col", 32'(kp.col_out), 32'(col_mask((k / 4) % 4)));
    end

    // Table of single presses.
    for (int i = 0; i < 4; i++) begin
      n0 = obs_q.size();
      t0 = cyc;
      expect_key(vecs[i].code);
      pressed[vecs[i].row*4 + vecs[i].col] = 1'b1;
      wait_pulse(n0, 2 * MAX_LAT, got);
      check("press_seen", 32'(got), 32'(1'b1));
      if (got) check("press_latency_ok", 32'((obs_cyc[n0] - t0) <= MAX_LAT), 32'(1'b1));
      repeat (40) @(negedge clk);
      check("press_key_down", 32'(kp.key_down), 32'(1'b1));
      check("press_one_pulse", 32'(obs_q.size()), 32'(n0 + 1));
      sb_check();
      pressed = '0;
      wait_fall(20, nf);
      check("release_latency", 32'(nf), 32'(2 + DEB));
      check("resume_col", 32'(kp.col_out), 32'(col_mask((vecs[i].col + 1) % 4)));
      check("code_held", 32'(kp.key_code), 32'(vecs[i].code));
      repeat (5) @(negedge clk);
    end

    // Bounce on (0,3): 2 cycles down, 2 up, never stable long enough.
    n0 = obs_q.size(); bad = 0; changes = 0; prev = kp.col_out;
    for (int t = 0; t < 40; t++) begin
      pressed[3] = ((t / 2) % 2) == 0;
      @(negedge clk);
      if (kp.key_down) bad++;
      if (kp.col_out != prev) changes++;
      prev = kp.col_out;
    end
    pressed = '0;
    repeat (20) @(negedge clk);
    check("bounce_no_pulse", 32'(obs_q.size()), 32'(n0));
    check("bounce_key_down_low", 32'(bad), 32'(0));
    check("bounce_still_scanning", 32'(changes >= 2), 32'(1'b1));
    sb_check();

    // Rows 1 and 3 of column 2 together: row 1 wins.
    n0 = obs_q.size();
    expect_key(4'h6);
    pressed[1*4+2] = 1'b1; pressed[3*4+2] = 1'b1;
    wait_pulse(n0, 2 * MAX_LAT, got);
    check("multi_seen", 32'(got), 32'(1'b1));
    sb_check();
    repeat (10) @(negedge clk);
    pressed[1*4+2] = 1'b0;
    repeat (30) @(negedge clk);
    check("multi_partial_no_pulse", 32'(obs_q.size()), 32'(n0 + 1));
    check("multi_partial_key_down", 32'(kp.key_down), 32'(1'b1));
    pressed = '0;
    wait_fall(20, nf);
    check("multi_release_latency", 32'(nf), 32'(2 + DEB));
    repeat (5) @(negedge clk);

    // Release glitch during HOLD on (1,0).
    n0 = obs_q.size();
    expect_key(4'h4);
    pressed[1*4+0] = 1'b1;
    wait_pulse(n0, 2 * MAX_LAT, got);
    check("glitch_seen", 32'(got), 32'(1'b1));
    repeat (5) @(negedge clk);
    bad = 0;
    pressed[4] = 1'b0;
    repeat (2) begin @(negedge clk); if (!kp.key_down) bad++; end
    pressed[4] = 1'b1;
    repeat (10) begin @(negedge clk); if (!kp.key_down) bad++; end
    check("glitch_key_down_held", 32'(bad), 32'(0));
    pressed = '0;
    wait_fall(20, nf);
    check("glitch_release_latency", 32'(nf), 32'(2 + DEB));
    check("glitch_one_pulse", 32'(obs_q.size()), 32'(n0 + 1));
    sb_check();
    repeat (5) @(negedge clk);

    // Reset during DEBOUNCE of (3,3), then normal acceptance after reset.
    got = 1'b0;
    for (int i = 0; i < 20 && kp.col_out == 4'b0111; i++) @(negedge clk);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (kp.col_out == 4'b0111) got = 1'b1;
    end
    check("reach_col3", 32'(got), 32'(1'b1));
    n0 = obs_q.size();
    pressed[15] = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_col_out",   32'(kp.col_out),   32'(4'b1110));
    check("midrst_key_code",  32'(kp.key_code),  32'(4'h0));
    check("midrst_key_valid", 32'(kp.key_valid), 32'(1'b0));
    check("midrst_key_down",  32'(kp.key_down),  32'(1'b0));
    repeat (3) @(negedge clk);
    check("midrst_no_pulse", 32'(obs_q.size()), 32'(n0));
    expect_key(4'hF);
    rst_n = 1'b1;
    wait_pulse(n0, 2 * MAX_LAT, got);
    check("post_rst_seen", 32'(got), 32'(1'b1));
    sb_check();
    pressed = '0;
    wait_fall(20, nf);
    check("post_rst_release_latency", 32'(nf), 32'(2 + DEB));

    repeat (10) @(negedge clk);
    sb_check();
    check("all_expected_consumed", 32'(exp_q.size()), 32'(0));
    check("total_pulses", 32'(obs_q.size()), 32'(n_exp));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 matrix keypad by driving one column low at a time and sampling the four row lines. It synchronizes and debounces the rows, then reports one debounced key code per press. It is the input-side counterpart of the LED matrix row scanner: the same style of one-hot matrix multiplexing, but reading a matrix instead of driving one. It runs on the same divided scan clock and feeds key codes to the control logic that selects display patterns.

## Interface
- DWELL, 4: cycles each column is driven before its rows are sampled; minimum 3, which covers synchronizer latency plus settling.
- DEBOUNCE_CYCLES, 4: consecutive stable synchronized samples required to accept a press or a release; minimum 1.
- divided_clk  in  1  scan clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- row_in  in  4  keypad rows; active-low (pulled up, 0 = pressed key on the driven column); asynchronous to divided_clk.
- col_out  out  4  keypad columns; active-low one-cold (exactly one bit 0).
- key_code  out  4  last accepted key, row*4 + col; held until the next accepted press.
- key_valid  out  1  one-cycle pulse when key_code updates.
- key_down  out  1  high from the accepted press until the accepted release.

## Operation
- row_in passes through a 2-flop synchronizer, producing row_s. Reset value is 4'b1111. All decisions use row_s only.
- col_out = ~(4'b0001 << col_idx), where col_idx is 2 bits and wraps 3 -> 0.
- FSM states: SCAN, DEBOUNCE, HOLD.
- **SCAN**
  - dwell_cnt counts 0..DWELL-1 with col_out steady.
  - At dwell_cnt == DWELL-1, if row_s == 4'b1111: col_idx increments, dwell_cnt clears, and the FSM stays in SCAN.
  - Otherwise: cap_row = index of the lowest-numbered 0 bit of row_s (priority row 0), cap_pat = row_s, deb_cnt = 0, and the FSM goes to DEBOUNCE.
- **DEBOUNCE**
  - col_out stays frozen.
  - Each cycle with row_s == cap_pat increments deb_cnt.
  - When deb_cnt reaches DEBOUNCE_CYCLES-1 on a matching cycle:
    - key_code <= {cap_row, col_idx}
    - key_valid <= 1
    - key_down <= 1
    - next state HOLD, deb_cnt cleared.
  - Any mismatching cycle: col_idx increments, dwell_cnt clears, and the FSM returns to SCAN with no output change.
- **HOLD**
  - col_out stays frozen.
  - Each cycle with row_s == 4'b1111 increments deb_cnt; any cycle with row_s != 4'b1111 clears deb_cnt.
  - When deb_cnt reaches DEBOUNCE_CYCLES-1 on an all-high cycle: key_down <= 0, col_idx increments, dwell_cnt clears, and the FSM returns to SCAN.
- Keys in other columns cannot be seen while the FSM is frozen in HOLD. A second key in the same column does not produce a new key_valid (one press = one pulse).
- Multiple rows low at capture: the lowest row index wins.
- key_valid is registered and forced to 0 on every cycle except the single acceptance cycle.
- Counter widths: at least clog2 of the larger parameter. Counters never wrap inside a state because they are cleared on every state exit.

## Timing
- Reset values (asynchronous, while rst_n = 0):
  - col_out = 4'b1110 (col_idx 0)
  - key_code = 4'h0
  - key_valid = 0
  - key_down = 0
  - state SCAN, dwell_cnt = 0, deb_cnt = 0, synchronizer 4'b1111.
- After rst_n deasserts, the first edge advances dwell_cnt. No output changes until the first column sample.
- Full scan period with no key pressed: 4*DWELL cycles.
- Press latency, from a stable row_in change to key_valid high: at most 2 (sync) + 4*DWELL + DEBOUNCE_CYCLES + 1 cycles.
- Release latency, from a stable all-high row_in to key_down low: 2 + DEBOUNCE_CYCLES cycles.
- rst_n asserted in any state: immediate return to reset values. A pending press is lost, and no key_valid is emitted for it.
- A key pressed during the final dwell cycle may be missed in that scan; it is caught one scan later.

## Test plan
The bench keypad model drives row_in[r] = 0 iff key (r,c) is pressed and col_out[c] = 0. All scenarios use DWELL = 4 and DEBOUNCE_CYCLES = 4.
- **Reset:** hold rst_n = 0 with arbitrary row_in -> col_out = 4'b1110, key_code = 0, key_valid = 0, key_down = 0. After release, col_out cycles 1110 -> 1101 -> 1011 -> 0111 -> 1110, each held 4 cycles.
- **Single press:** press (row 2, col 1) for 60 cycles, then release -> exactly one key_valid pulse with key_code = 4'h9. key_down stays high until 6 cycles after the release, and scanning resumes at col 2.
- **Bounce rejection:** (row 0, col 3) toggles every 2 cycles for 40 cycles, then releases -> no key_valid, key_down stays 0, and col_out keeps scanning.
- **Same-column multi-key:** press rows 1 and 3 of col 2 together -> one key_valid with key_code = 4'h6 (row 1 wins). Releasing row 1 only produces no further pulse, and key_down stays 1.
- **Release glitch:** during HOLD on (1, 0), drop the key for 2 cycles, re-press for 10 cycles, then release -> no second key_valid. key_down falls 6 cycles after the final release.
- **Reset mid-operation:** assert rst_n = 0 during DEBOUNCE of (3, 3) -> all reset values immediately, no key_valid. After reset is released with the key still held, a normal acceptance of key_code = 4'hF follows.
